// File: rtl/btn_conditioner.sv
// Push-button front end: per-lane synchroniser, debounce, press pulse and
// optional auto-repeat, producing one strobe per physical press.
module btn_conditioner #(
    parameter int          DEBOUNCE_CYCLES = 1000000,
    parameter int          REPEAT_DELAY    = 50000000,
    parameter int          REPEAT_PERIOD   = 20000000,
    parameter logic [4:0]  REPEAT_MASK     = 5'b01111,
    parameter int          CNT_W           = 26
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] btn_in,
    output logic [4:0] btn_level,
    output logic [4:0] btn_pulse,
    output logic       any_pulse
);

    localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] HOLD_RELOAD = CNT_W'(REPEAT_DELAY - REPEAT_PERIOD);
    localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);

    logic [4:0]       s1;
    logic [4:0]       s2;
    logic [CNT_W-1:0] dcnt     [5];
    logic [CNT_W-1:0] dcnt_nxt [5];
    logic [CNT_W-1:0] hcnt     [5];
    logic [CNT_W-1:0] hcnt_nxt [5];
    logic [4:0]       level_nxt;
    logic [4:0]       pulse_nxt;
    logic [4:0]       settle;

    always_comb begin
        settle    = '0;
        level_nxt = btn_level;
        pulse_nxt = '0;
        for (int i = 0; i < 5; i++) begin
            dcnt_nxt[i] = dcnt[i];
            hcnt_nxt[i] = hcnt[i];

            settle[i] = (s2[i] != btn_level[i]) && (dcnt[i] == DEB_LAST);
            if (s2[i] == btn_level[i]) begin
                dcnt_nxt[i] = '0;
            end else if (settle[i]) begin
                level_nxt[i] = s2[i];
                dcnt_nxt[i]  = '0;
            end else begin
                dcnt_nxt[i] = dcnt[i] + ONE;
            end

            // A settling edge in either direction restarts the hold timer and
            // suppresses any repeat that would coincide with a release.
            if (!btn_level[i] || settle[i]) begin
                hcnt_nxt[i]  = '0;
                pulse_nxt[i] = settle[i] && s2[i];
            end else if (REPEAT_MASK[i]) begin
                if (hcnt[i] == HOLD_LAST) begin
                    hcnt_nxt[i]  = HOLD_RELOAD;
                    pulse_nxt[i] = 1'b1;
                end else begin
                    hcnt_nxt[i] = hcnt[i] + ONE;
                end
            end else begin
                hcnt_nxt[i] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1        <= '0;
            s2        <= '0;
            btn_level <= '0;
            btn_pulse <= '0;
            any_pulse <= 1'b0;
            for (int i = 0; i < 5; i++) begin
                dcnt[i] <= '0;
                hcnt[i] <= '0;
            end
        end else begin
            s1        <= btn_in;
            s2        <= s1;
            btn_level <= level_nxt;
            btn_pulse <= pulse_nxt;
            any_pulse <= |pulse_nxt;
            for (int i = 0; i < 5; i++) begin
                dcnt[i] <= dcnt_nxt[i];
                hcnt[i] <= hcnt_nxt[i];
            end
        end
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: directed scenarios plus random button activity,
// every cycle compared against a window/schedule reference model.
module tb_btn_conditioner;

    localparam int         DEB    = 4;
    localparam int         DELAY  = 10;
    localparam int         PERIOD = 3;
    localparam logic [4:0] MASK   = 5'b01111;

    logic       clk;
    logic       rst_n;
    logic [4:0] btn_in;
    logic [4:0] btn_level;
    logic [4:0] btn_pulse;
    logic       any_pulse;

    int checks;
    int errors;

    btn_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY   (DELAY),
        .REPEAT_PERIOD  (PERIOD),
        .REPEAT_MASK    (MASK),
        .CNT_W          (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_in   (btn_in),
        .btn_level(btn_level),
        .btn_pulse(btn_pulse),
        .any_pulse(any_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a level flips once the last DEB synchronised samples
    // all disagree with it; repeats follow a fixed schedule from the press.
    logic [4:0] m_level;
    logic [4:0] m_pulse;
    logic       m_any;
    logic [4:0] pin_q [$];
    logic [4:0] s2_q  [$];
    int         t0 [5];
    int         edge_n;

    function void model_reset();
        pin_q.delete();
        s2_q.delete();
        m_level = '0;
        m_pulse = '0;
        m_any   = 1'b0;
        edge_n  = 0;
    endfunction

    function void model_edge(input logic [4:0] pin);
        logic [4:0] s2;
        logic       flip;
        edge_n++;
        pin_q.push_back(pin);
        s2 = (pin_q.size() >= 3) ? pin_q[pin_q.size()-3] : 5'b0;
        if (pin_q.size() > 3) void'(pin_q.pop_front());
        s2_q.push_back(s2);
        if (s2_q.size() > DEB) void'(s2_q.pop_front());
        m_pulse = '0;
        for (int i = 0; i < 5; i++) begin
            flip = (s2_q.size() == DEB);
            foreach (s2_q[k]) if (s2_q[k][i] == m_level[i]) flip = 1'b0;
            if (flip) begin
                m_level[i] = ~m_level[i];
                if (m_level[i]) begin
                    m_pulse[i] = 1'b1;
                    t0[i]      = edge_n;
                end
            end else if (m_level[i] && MASK[i] && (edge_n - t0[i] >= DELAY)
                         && ((edge_n - t0[i] - DELAY) % PERIOD == 0)) begin
                m_pulse[i] = 1'b1;
            end
        end
        m_any = |m_pulse;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_edge(btn_in);
        #1;
        chk("model_level", btn_level, m_level);
        chk("model_pulse", btn_pulse, m_pulse);
        chk("model_any",   any_pulse, m_any);
    endtask

    task automatic assert_reset(input logic [4:0] pins);
        btn_in = pins;
        rst_n  = 1'b0;
        #1;
        model_reset();
        chk("rst_async_level", btn_level, 5'b0);
        chk("rst_async_pulse", btn_pulse, 5'b0);
        chk("rst_async_any",   any_pulse, 1'b0);
        step();
        step();
        rst_n = 1'b1;
    endtask

    int          cnt;
    int          pos;
    int          fall_off;
    int          got [$];
    int          exp_rep [10] = '{0, 10, 13, 16, 19, 22, 25, 28, 31, 34};
    int          dur [5];
    logic        found;

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        btn_in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;

        // Reset with all buttons held: press pulses on the 6th edge after release
        assert_reset(5'h1F);
        for (int k = 1; k <= 7; k++) begin
            step();
            if (k == 6) begin
                chk("held_level6", btn_level, 5'h1F);
                chk("held_pulse6", btn_pulse, 5'h1F);
                chk("held_any6",   any_pulse, 1'b1);
            end else begin
                chk("held_pulse_other", btn_pulse, 5'h00);
            end
        end

        // Bounce rejection on btnL
        assert_reset(5'h00);
        repeat (2) step();
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            btn_in[2] = ~btn_in[2];
            step(); if (btn_pulse[2]) cnt++;
            step(); if (btn_pulse[2]) cnt++;
        end
        btn_in[2] = 1'b1;
        pos = 0;
        for (int k = 1; k <= 9; k++) begin
            step();
            if (btn_pulse[2]) begin cnt++; pos = k; end
        end
        chk("bounce_count", cnt, 1);
        chk("bounce_edge",  pos, 6);

        btn_in[2] = 1'b0;
        repeat (8) step();
        btn_in[2] = 1'b1;
        repeat (3) step();
        btn_in[2] = 1'b0;
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (btn_pulse[2] || btn_level[2]) cnt++;
        end
        chk("glitch_activity", cnt, 0);

        // Auto-repeat on btnR with release landing on a repeat slot
        btn_in[3] = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            step();
            if (btn_pulse[3]) found = 1'b1;
        end
        chk("rep_press_seen", found, 1'b1);
        got.delete();
        got.push_back(0);
        for (int off = 1; off <= 31; off++) begin
            step();
            if (btn_pulse[3]) got.push_back(off);
        end
        btn_in[3] = 1'b0;
        fall_off = -1;
        for (int off = 32; off <= 45; off++) begin
            step();
            if (btn_pulse[3]) got.push_back(off);
            if (!btn_level[3] && fall_off < 0) fall_off = off;
        end
        chk("rep_count", got.size(), 10);
        for (int k = 0; k < 10 && k < got.size(); k++) chk("rep_offset", got[k], exp_rep[k]);
        chk("rel_fall_offset", fall_off, 37);

        // btnC has repeat masked off
        btn_in[4] = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            step();
            if (btn_pulse[4]) found = 1'b1;
        end
        chk("c_press_seen", found, 1'b1);
        cnt = 0;
        for (int k = 0; k < 30; k++) begin
            step();
            if (btn_pulse[4]) cnt++;
        end
        chk("c_no_repeat", cnt, 0);
        btn_in[4] = 1'b0;
        repeat (8) step();

        // Simultaneous btnL + btnR
        btn_in = 5'b01100;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            step();
            if (any_pulse) found = 1'b1;
        end
        chk("simul_seen",  found, 1'b1);
        chk("simul_pulse", btn_pulse, 5'b01100);
        chk("simul_any",   any_pulse, 1'b1);
        btn_in = 5'b00000;
        repeat (8) step();

        // Reset mid-repeat on btnR and two cycles into a btnU debounce
        btn_in[3] = 1'b1;
        repeat (18) step();
        chk("pre_rst_level", btn_level[3], 1'b1);
        btn_in[0] = 1'b1;
        step();
        step();
        #3;
        assert_reset(5'b00001);
        pos = 0;
        cnt = 0;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (btn_pulse[0]) begin cnt++; pos = k; end
        end
        chk("rst_u_count", cnt, 1);
        chk("rst_u_edge",  pos, 6);

        // Random button activity with mixed hold lengths
        assert_reset(5'h00);
        for (int i = 0; i < 5; i++) dur[i] = $urandom_range(1, 18);
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < 5; i++) begin
                if (dur[i] == 0) begin
                    btn_in[i] = ~btn_in[i];
                    dur[i]    = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 40)
                                                            : $urandom_range(1, 8);
                end else begin
                    dur[i]--;
                end
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
